instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage sitting directly downstream of `program_counter`: consumes the current PC, issues in-order word requests to instruction memory over a valid/ready channel, and advances the PC only when a request is accepted. Returned words are paired with their PC and queued for decode behind a valid/ready output. Redirects from execute reload the PC and discard every in-flight and queued fetch.

## Interface
- `DEPTH`, 4: output queue entries; also the cap on outstanding requests plus queued entries (power of two, ≥2).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pc_in` in 32: current PC, from `program_counter.c_out`.
- `pc_en` out 1: load strobe to `program_counter.en`.
- `pc_next` out 32: value to load, to `program_counter.c_in`.
- `redirect_valid` in 1: branch/jump taken, single-cycle pulse.
- `redirect_pc` in 32: redirect target.
- `imem_req_valid` out 1: fetch request.
- `imem_req_addr` out 32: `{pc_in[31:2], 2'b00}`.
- `imem_req_ready` in 1: memory accepts request.
- `imem_rsp_valid` in 1: response word valid; in order, ≥1 cycle after acceptance, never back-pressured.
- `imem_rsp_data` in 32: instruction word.
- `if_valid` out 1: decode entry available.
- `if_pc` out 32: PC of entry.
- `if_instr` out 32: instruction of entry.
- `if_ready` in 1: decode consumes entry.

## Operation
- Counters: `out_cnt` (accepted, unreturned requests, 0..DEPTH), `drop_cnt` (stale in-flight responses still to discard), queue occupancy `q_cnt`.
- Issue: `imem_req_valid = rst && !redirect_valid && (out_cnt + q_cnt < DEPTH)`; all terms registered except `redirect_valid`. A pop in the same cycle frees no credit until the next cycle.
- Accept (`imem_req_valid && imem_req_ready`): `pc_en=1`, `pc_next=pc_in+4` (mod 2^32, 0xFFFFFFFC wraps to 0); `pc_in` pushed to the in-flight PC queue; `out_cnt++`.
- Redirect: `pc_en=1`, `pc_next=redirect_pc`, priority over accept; output queue cleared; `drop_cnt <= out_cnt - imem_rsp_valid`; a response arriving that same cycle is discarded.
- Response: pop in-flight PC; `out_cnt--`; if `drop_cnt>0` decrement and discard, else push `{pc, imem_rsp_data}` to output queue.
- Output: `if_valid = q_cnt != 0`; pop on `if_valid && if_ready`. Simultaneous push and pop leaves `q_cnt` unchanged.
- Credit rule guarantees queue never overflows; a response with `out_cnt==0` is a protocol error (assertion only, no recovery).
- No separate FSM: mode is fully captured by `out_cnt`/`drop_cnt`; "draining" ≡ `drop_cnt>0`, during which new requests still issue.

## Timing
- Reset (`rst`=0, async): `out_cnt`, `drop_cnt`, `q_cnt`, queue pointers = 0; `if_valid`=0, `imem_req_valid`=0, `pc_en`=0, `pc_next`=0, `if_pc`/`if_instr`=0. First request may issue the first edge after release.
- `pc_en`, `pc_next`, `imem_req_valid`, `imem_req_addr` combinational from registered state and `pc_in`/`redirect_*`/`imem_req_ready`; PC updates on the edge where `pc_en`=1.
- Latency: request accepted at edge N, response at N+k (k≥1), `if_valid` asserted after edge N+k (queue registered). Minimum request-to-decode: 2 cycles.
- Throughput: 1 instr/cycle sustained with k=1, `if_ready`=1, DEPTH≥4.
- Redirect at edge R: first request at target issues in cycle after R; nothing fetched before R ever reaches decode.
- Reset mid-operation: all in-flight state lost; memory side must be reset together.

## Structure
- `fetch_pkg`: `XLEN=32`, `INSTR_BYTES=4`, `fetch_entry_t` struct `{pc, instr}`.
- Sub-module `fetch_fifo` (parameterised width/depth, sync, async active-low clear, sync flush), instantiated twice: in-flight PC queue and output queue.
- Credit/drop counters and PC-select mux live in `instruction_fetch`.

## Test plan
- Reset with `pc_in`=0, mem k=1, `if_ready`=1 -> addresses 0x0,0x4,0x8... one per cycle; `if_pc`=0x0 with word at 0x0 two cycles after first accept.
- `imem_req_ready` low 3 cycles -> `pc_en`=0, `pc_in` held at 0x10, no queue change; resumes at 0x10.
- `if_ready`=0, DEPTH=4 -> exactly 4 requests accepted, `imem_req_valid` drops; release -> entries 0x0..0xC in order.
- Redirect to 0x200 with 2 outstanding (k=3) and 1 queued -> queue empties, both stale responses discarded, next `if_pc`=0x200.
- Redirect coinciding with response -> response discarded, `drop_cnt`=`out_cnt`-1; `pc_in`=0xFFFFFFFC accept -> `pc_next`=0x0.
- Assert `rst` low with 2 in flight -> all outputs 0 immediately, no stale entry after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    // One decoded-ready entry: the fetch PC and the word returned for it.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with asynchronous active-low clear and synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Pointer and occupancy next-state; flush wins over push and pop.
    always_comb begin
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage; cleared on reset so the read port shows zero afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
        end else if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Head of queue and occupancy.
    always_comb begin
        pop_data = mem_q[rd_ptr_q];
        count    = cnt_q;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues in-order word requests from the current PC, pairs returned words with
// their PC and queues them for decode. Redirects reload the PC and squash older fetches.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_en,
    output logic [XLEN-1:0] pc_next,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    input  logic            if_ready
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = $bits(fetch_entry_t);

    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   q_cnt, infl_cnt;
    logic [CW:0]     credit_used;
    logic            accept, discard, q_push, q_pop;
    logic [XLEN-1:0] infl_pc;
    fetch_entry_t    q_wdata, q_rdata;

    // Request issue and PC select; redirect has priority over a normal advance.
    always_comb begin
        credit_used    = {1'b0, out_cnt_q} + {1'b0, q_cnt};
        imem_req_valid = rst && !redirect_valid && (credit_used < (CW + 1)'(DEPTH));
        imem_req_addr  = {pc_in[XLEN-1:2], 2'b00};
        accept         = imem_req_valid && imem_req_ready;
        pc_en          = rst && (redirect_valid || accept);
        pc_next        = '0;
        if (rst && redirect_valid) begin
            pc_next = redirect_pc;
        end else if (accept) begin
            pc_next = pc_in + XLEN'(INSTR_BYTES);
        end
    end

    // Response routing: stale responses (older than a redirect) are dropped.
    always_comb begin
        discard       = redirect_valid || (drop_cnt_q != '0);
        q_push        = imem_rsp_valid && !discard;
        q_pop         = if_valid && if_ready;
        q_wdata.pc    = infl_pc;
        q_wdata.instr = imem_rsp_data;
    end

    // Credit and drop counter next-state; no accept can coincide with a redirect.
    always_comb begin
        out_cnt_d  = out_cnt_q + CW'(accept) - CW'(imem_rsp_valid);
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            drop_cnt_d = out_cnt_q - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    // Credit and drop counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // PCs of accepted requests, popped in order as responses return (stale ones included).
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_infl_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (accept),
        .push_data (pc_in),
        .pop       (imem_rsp_valid),
        .pop_data  (infl_pc),
        .count     (infl_cnt)
    );

    // Entries waiting for decode; emptied on redirect.
    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data (q_wdata),
        .pop       (q_pop),
        .pop_data  (q_rdata),
        .count     (q_cnt)
    );

    // Decode-facing outputs.
    always_comb begin
        if_valid = (q_cnt != '0);
        if_pc    = q_rdata.pc;
        if_instr = q_rdata.instr;
    end

    // A response with nothing outstanding is a memory protocol violation.
    a_rsp_outstanding : assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> ((out_cnt_q != '0) && (infl_cnt == out_cnt_q)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: program counter, memory and decode are modelled
// as queues of outstanding work tagged with a redirect epoch.
module tb_instruction_fetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready = 1'b0;

    instruction_fetch #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_en          (pc_en),
        .pc_next        (pc_next),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; }          mreq_t;
    typedef struct { logic [31:0] pc; int epoch; }          infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    mreq_t mem_q[$];
    infl_t infl_q[$];
    ent_t  dec_q[$];

    logic [31:0] pc;      // program counter model
    int cycle = 0;
    int epoch = 0;
    int k_min = 1, k_max = 1;
    int checks = 0, errors = 0;

    bit          last_acc, last_pop, last_ifv, last_req;
    logic [31:0] last_addr, last_pop_pc, last_pc_next;

    assign pc_in = pc;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // One clock cycle: drive inputs, check combinational outputs against the model, advance.
    task automatic step(input bit req_rdy, input bit dec_rdy, input bit redir,
                        input logic [31:0] tgt);
        bit          exp_req, acc, pop, rsp, exp_en;
        logic [31:0] exp_next;
        mreq_t       m;
        infl_t       f;
        logic        en_s;
        logic [31:0] next_s;
        imem_req_ready = req_rdy;
        if_ready       = dec_rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        rsp = (mem_q.size() != 0) && (mem_q[0].due <= cycle);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? word_at(mem_q[0].addr) : $urandom();
        #1;
        exp_req = !redir && ((infl_q.size() + dec_q.size()) < DEPTH);
        checks++;
        if (imem_req_valid !== exp_req) begin
            errors++;
            $display("FAIL req_valid cyc %0d: got %b want %b", cycle, imem_req_valid, exp_req);
        end
        checks++;
        if (imem_req_addr !== {pc[31:2], 2'b00}) begin
            errors++;
            $display("FAIL req_addr cyc %0d: got %h want %h", cycle, imem_req_addr,
                     {pc[31:2], 2'b00});
        end
        acc      = exp_req && req_rdy;
        exp_en   = redir || acc;
        exp_next = redir ? tgt : (acc ? pc + 32'd4 : 32'd0);
        checks++;
        if (pc_en !== exp_en) begin
            errors++;
            $display("FAIL pc_en cyc %0d: got %b want %b", cycle, pc_en, exp_en);
        end
        checks++;
        if (pc_next !== exp_next) begin
            errors++;
            $display("FAIL pc_next cyc %0d: got %h want %h", cycle, pc_next, exp_next);
        end
        checks++;
        if (if_valid !== (dec_q.size() != 0)) begin
            errors++;
            $display("FAIL if_valid cyc %0d: got %b want %b", cycle, if_valid, dec_q.size() != 0);
        end
        if (dec_q.size() != 0) begin
            checks++;
            if (if_pc !== dec_q[0].pc || if_instr !== dec_q[0].instr) begin
                errors++;
                $display("FAIL entry cyc %0d: got %h/%h want %h/%h", cycle, if_pc, if_instr,
                         dec_q[0].pc, dec_q[0].instr);
            end
        end
        pop          = (dec_q.size() != 0) && dec_rdy;
        last_acc     = acc;
        last_req     = imem_req_valid;
        last_ifv     = if_valid;
        last_addr    = {pc[31:2], 2'b00};
        last_pop     = pop;
        last_pop_pc  = pop ? dec_q[0].pc : 32'h0;
        last_pc_next = pc_next;
        en_s         = pc_en;
        next_s       = pc_next;
        if (pop) void'(dec_q.pop_front());
        if (redir) begin
            epoch++;
            dec_q.delete();
        end
        if (rsp) begin
            m = mem_q.pop_front();
            f = infl_q.pop_front();
            if (f.epoch == epoch) dec_q.push_back('{pc: f.pc, instr: word_at(m.addr)});
        end
        if (acc) begin
            infl_q.push_back('{pc: pc, epoch: epoch});
            mem_q.push_back('{addr: {pc[31:2], 2'b00}, due: cycle + $urandom_range(k_max, k_min)});
        end
        @(posedge clk);
        @(negedge clk);
        if (en_s === 1'b1) pc = next_s;
        cycle++;
    endtask

    // Assert reset (memory and program counter reset with it) and check outputs go quiet.
    task automatic do_reset(input string tag);
        imem_req_ready = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        rst            = 1'b0;
        pc             = 32'h0;
        #1;
        checks++;
        if (pc_en !== 1'b0 || pc_next !== 32'h0) begin
            errors++;
            $display("FAIL %s pc_en/pc_next: got %b/%h want 0/0", tag, pc_en, pc_next);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s req_valid: got %b want 0", tag, imem_req_valid);
        end
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s if_valid: got %b want 0", tag, if_valid);
        end
        checks++;
        if (if_pc !== 32'h0 || if_instr !== 32'h0) begin
            errors++;
            $display("FAIL %s entry: got %h/%h want 0/0", tag, if_pc, if_instr);
        end
        mem_q.delete();
        infl_q.delete();
        dec_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    // Back-to-back fetch with k=1: one accept per cycle, first decode two cycles after accept.
    task automatic test_stream();
        int first_acc = -1, first_ifv = -1, n = 0;
        bit pop0_ok = 0;
        k_min = 1; k_max = 1;
        do_reset("stream");
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 0);
            if (last_acc) begin
                if (first_acc < 0) first_acc = i;
                checks++;
                if (last_addr !== 32'(4 * n)) begin
                    errors++;
                    $display("FAIL stream addr %0d: got %h want %h", n, last_addr, 4 * n);
                end
                n++;
            end
            if (last_ifv && first_ifv < 0) begin
                first_ifv = i;
                pop0_ok = last_pop && (last_pop_pc === 32'h0);
            end
        end
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL stream throughput: got %0d accepts want 12", n);
        end
        checks++;
        if (first_ifv - first_acc != 2 || !pop0_ok) begin
            errors++;
            $display("FAIL stream latency: got %0d cycles (pc0 ok %b) want 2 (1)",
                     first_ifv - first_acc, pop0_ok);
        end
    endtask

    // Memory stall: PC holds at 0x10 and fetch resumes there.
    task automatic test_stall();
        k_min = 1; k_max = 1;
        do_reset("stall");
        repeat (4) step(1, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        checks++;
        if (pc !== 32'h10) begin
            errors++;
            $display("FAIL stall pc: got %h want 00000010", pc);
        end
        step(1, 1, 0, 0);
        checks++;
        if (!last_acc || last_addr !== 32'h10) begin
            errors++;
            $display("FAIL stall resume: got acc %b addr %h want 1 00000010", last_acc, last_addr);
        end
        repeat (4) step(1, 1, 0, 0);
    endtask

    // Decode stalled: credit limits fetch to DEPTH, then entries drain in order.
    task automatic test_backpressure();
        int n = 0;
        logic [31:0] got[$];
        k_min = 1; k_max = 1;
        do_reset("bp");
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0);
            if (last_acc) n++;
        end
        checks++;
        if (n != DEPTH || last_req !== 1'b0) begin
            errors++;
            $display("FAIL bp credit: got %0d accepts req %b want %0d 0", n, last_req, DEPTH);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0);
            if (last_pop) got.push_back(last_pop_pc);
        end
        checks++;
        if (got.size() != DEPTH) begin
            errors++;
            $display("FAIL bp drain count: got %0d want %0d", got.size(), DEPTH);
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== 32'(4 * i)) begin
                errors++;
                $display("FAIL bp order %0d: got %h want %h", i, got[i], 4 * i);
            end
        end
    endtask

    // Redirect with two outstanding (k=3) and one queued entry.
    task automatic test_redirect();
        logic [31:0] got[$];
        k_min = 3; k_max = 3;
        do_reset("redir");
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if (infl_q.size() != 2 || dec_q.size() != 1) begin
            errors++;
            $display("FAIL redir setup: got %0d outstanding %0d queued want 2 1",
                     infl_q.size(), dec_q.size());
        end
        step(0, 0, 1, 32'h200);
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 0);
            if (last_pop) got.push_back(last_pop_pc);
        end
        checks++;
        if (got.size() == 0 || got[0] !== 32'h200) begin
            errors++;
            $display("FAIL redir first: got %h want 00000200", got.size() ? got[0] : 32'hx);
        end
    endtask

    // Redirect coinciding with a response, then a fetch at the top of the address space.
    task automatic test_redirect_rsp_wrap();
        logic [31:0] got[$];
        k_min = 2; k_max = 2;
        do_reset("redir_rsp");
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h300);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 0);
            if (last_pop) got.push_back(last_pop_pc);
        end
        checks++;
        if (got.size() == 0 || got[0] !== 32'h300) begin
            errors++;
            $display("FAIL redir_rsp first: got %h want 00000300", got.size() ? got[0] : 32'hx);
        end
        got.delete();
        step(0, 1, 1, 32'hFFFF_FFFC);
        step(1, 1, 0, 0);
        checks++;
        if (!last_acc || last_pc_next !== 32'h0) begin
            errors++;
            $display("FAIL wrap pc_next: got acc %b next %h want 1 00000000", last_acc, last_pc_next);
        end
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 0);
            if (last_pop) got.push_back(last_pop_pc);
        end
        checks++;
        if (got.size() < 2 || got[0] !== 32'hFFFF_FFFC || got[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap order: got %0d entries first %h want fffffffc then 0",
                     got.size(), got.size() ? got[0] : 32'hx);
        end
    endtask

    // Reset asserted mid-cycle with two requests in flight.
    task automatic test_reset_mid();
        logic [31:0] got[$];
        k_min = 3; k_max = 3;
        do_reset("mid_pre");
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        #2;
        do_reset("mid");
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 0);
            if (last_pop) got.push_back(last_pop_pc);
        end
        checks++;
        if (got.size() == 0 || got[0] !== 32'h0) begin
            errors++;
            $display("FAIL mid first: got %h want 00000000", got.size() ? got[0] : 32'hx);
        end
    endtask

    // Random handshakes, latencies and redirects against the model.
    task automatic test_random();
        logic [31:0] tgt;
        do_reset("random");
        for (int i = 0; i < 800; i++) begin
            k_min = 1;
            k_max = 1 + (i / 200);
            tgt = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(9, 0) == 0) tgt = 32'hFFFF_FFF8;
            step($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 60,
                 $urandom_range(99, 0) < 5, tgt);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_backpressure();
        test_redirect();
        test_redirect_rsp_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
